// File: rtl/wb_seq_ctrl.sv
// wb_seq_ctrl: RV32I write-back stage sequencer.
// Commits one retiring instruction per handshake, drives the write-back mux
// select and register-file write port, and stalls execute while a load waits
// for its memory response (with timeout and flush abandonment).
module wb_seq_ctrl #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned RET_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_wb_type,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             mem_rsp_valid,
    input  logic             flush,
    output logic [1:0]       rd_sel,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic             pend_valid,
    output logic [4:0]       pend_rd,
    output logic             load_err,
    output logic [RET_W-1:0] retired
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] WB_LOAD = 2'b01;
    // Last counter value before the load is abandoned.
    localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [4:0]       r_ld_rd;
    logic             r_ld_rw;
    logic [1:0]       r_rd_sel;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic             r_pend_valid;
    logic [4:0]       r_pend_rd;
    logic             r_load_err;
    logic [RET_W-1:0] r_retired;

    logic w_ready;
    logic w_accept;
    logic w_ld_we;

    // Handshake: accept only in IDLE and never during a flush.
    always_comb begin
        w_ready  = (r_state == IDLE) && !flush;
        w_accept = ex_valid && w_ready;
        w_ld_we  = r_ld_rw && (r_ld_rd != 5'd0);
    end

    // Sequencer FSM with registered write-back outputs and load tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ld_rd      <= '0;
            r_ld_rw      <= 1'b0;
            r_rd_sel     <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_load_err   <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_rf_we    <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ld_rd <= ex_rd;
                        r_ld_rw <= ex_reg_write;
                        if (ex_wb_type == WB_LOAD) begin
                            r_state      <= LOAD_WAIT;
                            r_cnt        <= '0;
                            r_pend_valid <= ex_reg_write && (ex_rd != 5'd0);
                            r_pend_rd    <= (ex_reg_write && (ex_rd != 5'd0)) ? ex_rd : 5'd0;
                        end else begin
                            r_rf_we    <= ex_reg_write && (ex_rd != 5'd0);
                            r_rd_sel   <= ex_wb_type;
                            r_rf_waddr <= ex_rd;
                            r_retired  <= r_retired + RET_W'(1);
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (flush) begin
                        r_state      <= IDLE;
                        r_pend_valid <= 1'b0;
                        r_pend_rd    <= '0;
                    end else if (mem_rsp_valid) begin
                        r_state      <= IDLE;
                        r_pend_valid <= 1'b0;
                        r_pend_rd    <= '0;
                        r_rf_we      <= w_ld_we;
                        r_rd_sel     <= WB_LOAD;
                        r_rf_waddr   <= r_ld_rd;
                        r_retired    <= r_retired + RET_W'(1);
                    end else if (r_cnt == TO_LAST) begin
                        r_state      <= IDLE;
                        r_pend_valid <= 1'b0;
                        r_pend_rd    <= '0;
                        r_load_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output wiring.
    always_comb begin
        ex_ready   = w_ready;
        rd_sel     = r_rd_sel;
        rf_we      = r_rf_we;
        rf_waddr   = r_rf_waddr;
        pend_valid = r_pend_valid;
        pend_rd    = r_pend_rd;
        load_err   = r_load_err;
        retired    = r_retired;
    end

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Self-checking bench for wb_seq_ctrl: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_wb_seq_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid;
  logic       ex_ready;
  logic [1:0] ex_wb_type;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       mem_rsp_valid;
  logic       flush;
  logic [1:0] rd_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       pend_valid;
  logic [4:0] pend_rd;
  logic       load_err;
  logic [7:0] retired;

  wb_seq_ctrl #(.LOAD_TIMEOUT(TO), .RET_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wb_type(ex_wb_type), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_rsp_valid(mem_rsp_valid), .flush(flush), .rd_sel(rd_sel),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .pend_valid(pend_valid),
    .pend_rd(pend_rd), .load_err(load_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding load record plus expected commit results.
  bit         m_busy;
  logic [4:0] m_rd;
  bit         m_rw;
  int         m_age;
  bit         e_we;
  bit         e_err;
  logic [1:0] e_sel;
  logic [4:0] e_waddr;
  logic [7:0] e_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = '0; m_rw = 0; m_age = 0;
    e_we = 0; e_err = 0; e_sel = '0; e_waddr = '0; e_ret = '0;
  endtask

  // One clock cycle: drive, check combinational/pending outputs, advance model,
  // then check registered outputs just after the edge.
  task automatic cycle(input bit v, input logic [1:0] ty, input logic [4:0] rd,
                       input bit rw, input bit rsp, input bit fl);
    bit pv;
    ex_valid = v; ex_wb_type = ty; ex_rd = rd; ex_reg_write = rw;
    mem_rsp_valid = rsp; flush = fl;
    @(negedge clk);
    pv = m_busy && m_rw && (m_rd != 0);
    chk("ex_ready", ex_ready, !m_busy && !fl);
    chk("pend_valid", pend_valid, pv);
    chk("pend_rd", pend_rd, pv ? m_rd : 5'd0);
    e_we = 0; e_err = 0;
    if (!m_busy) begin
      if (v && !fl) begin
        if (ty == 2'b01) begin
          m_busy = 1; m_rd = rd; m_rw = rw; m_age = 0;
        end else begin
          e_we = rw && (rd != 0); e_sel = ty; e_waddr = rd; e_ret = e_ret + 8'd1;
        end
      end
    end else if (fl) begin
      m_busy = 0;
    end else if (rsp) begin
      e_we = m_rw && (m_rd != 0); e_sel = 2'b01; e_waddr = m_rd; e_ret = e_ret + 8'd1;
      m_busy = 0;
    end else begin
      m_age++;
      if (m_age == TO) begin
        e_err = 1; m_busy = 0;
      end
    end
    @(posedge clk); #1;
    chk("rf_we", rf_we, e_we);
    chk("load_err", load_err, e_err);
    chk("retired", retired, e_ret);
    if (e_we) begin
      chk("rd_sel", rd_sel, e_sel);
      chk("rf_waddr", rf_waddr, e_waddr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 2'b00, 5'd0, 0, 0, 0);
  endtask

  int err_pulses;

  initial begin
    rst_n = 0; ex_valid = 0; ex_wb_type = '0; ex_rd = '0; ex_reg_write = 0;
    mem_rsp_valid = 0; flush = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_pend_valid", pend_valid, 0);
    chk("rst_pend_rd", pend_rd, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_retired", retired, 0);

    // Back-to-back non-load commits.
    cycle(1, 2'b00, 5'd5, 1, 0, 0);
    chk("b2b_sel0", rd_sel, 2'b00);
    cycle(1, 2'b10, 5'd6, 1, 0, 0);
    chk("b2b_addr1", rf_waddr, 5'd6);
    cycle(1, 2'b11, 5'd1, 1, 0, 0);
    chk("b2b_sel2", rd_sel, 2'b11);
    chk("b2b_retired", retired, 8'd3);

    // Load rd=7, response on the last counted cycle before timeout.
    cycle(1, 2'b01, 5'd7, 1, 0, 0);
    chk("ld_pend", pend_valid, 1);
    idle(3);
    cycle(0, 2'b00, 5'd0, 0, 1, 0);
    chk("ld_commit_we", rf_we, 1);
    chk("ld_commit_sel", rd_sel, 2'b01);
    chk("ld_commit_ready", ex_ready, 1);

    // Load rd=9 with no response: timeout.
    err_pulses = 0;
    cycle(1, 2'b01, 5'd9, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 2'b00, 5'd0, 0, 0, 0);
      if (load_err) err_pulses++;
      if (i == 3) chk("to_err_cycle", load_err, 1);
    end
    chk("to_err_once", err_pulses, 1);
    chk("to_retired", retired, 8'd4);
    cycle(0, 2'b00, 5'd0, 0, 1, 0);   // stray response in IDLE

    // rd=0 write suppressed but instruction retires.
    cycle(1, 2'b00, 5'd0, 1, 0, 0);
    chk("rd0_retired", retired, 8'd5);

    // Flush while idle blocks acceptance.
    cycle(1, 2'b00, 5'd12, 1, 0, 1);

    // Load rd=3, flush and response together.
    cycle(1, 2'b01, 5'd3, 1, 0, 0);
    idle(1);
    cycle(0, 2'b00, 5'd0, 0, 1, 1);
    chk("fl_pend", pend_valid, 0);
    idle(2);

    // Reset pulse in the middle of an outstanding load.
    cycle(1, 2'b01, 5'd4, 1, 0, 0);
    idle(1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_pend", pend_valid, 0);
    chk("mid_rst_pend_rd", pend_rd, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_ready", ex_ready, 1);
    #3 rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    cycle(0, 2'b00, 5'd0, 0, 1, 0);
    chk("post_rst_we", rf_we, 0);

    // Randomized traffic (retired wraps at 8 bits).
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'(5'($urandom));
      cycle($urandom_range(0, 9) < 8, 2'($urandom), rd, $urandom_range(0, 5) != 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
